// File: rtl/gelato_bank_arbiter.sv
// Operand-collector read arbiter for the banked vector register file.
// Round-robin per bank, one-cycle tagged response pipeline.
module gelato_bank_arbiter #(
    parameter int COLLECTOR_NUM  = 4,
    parameter int BANK_NUM       = 4,
    parameter int RS_NUM         = 3,
    parameter int REG_NUM_WIDTH  = 5,
    parameter int WARP_NUM_WIDTH = 2,
    parameter int THREAD_NUM     = 4,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic [COLLECTOR_NUM*RS_NUM-1:0]                  req_valid,
    input  logic [COLLECTOR_NUM*WARP_NUM_WIDTH-1:0]          req_warp,
    input  logic [COLLECTOR_NUM*RS_NUM*REG_NUM_WIDTH-1:0]    req_reg,
    input  logic [BANK_NUM-1:0]                              wr_busy,
    input  logic                                             flush,
    output logic [COLLECTOR_NUM*RS_NUM-1:0]                  req_grant,
    output logic [BANK_NUM-1:0]                              rf_rd_en,
    output logic [BANK_NUM*(WARP_NUM_WIDTH+REG_NUM_WIDTH)-1:0] rf_rd_addr,
    input  logic [BANK_NUM*THREAD_NUM*DATA_WIDTH-1:0]        rf_rd_data,
    output logic [BANK_NUM-1:0]                              resp_valid,
    output logic [BANK_NUM*$clog2(COLLECTOR_NUM)-1:0]        resp_collector,
    output logic [BANK_NUM*2-1:0]                            resp_slot,
    output logic [BANK_NUM*THREAD_NUM*DATA_WIDTH-1:0]        resp_data
);

    localparam int RQ = COLLECTOR_NUM * RS_NUM;
    localparam int LB = $clog2(BANK_NUM);
    localparam int PW = $clog2(RQ);
    localparam int AW = WARP_NUM_WIDTH + REG_NUM_WIDTH;
    localparam int CW = $clog2(COLLECTOR_NUM);

    logic [RQ-1:0][LB-1:0]       w_bank;
    logic [BANK_NUM-1:0][RQ-1:0] w_elig;
    logic [BANK_NUM-1:0][PW-1:0] w_win;
    logic [BANK_NUM-1:0][CW-1:0] w_win_coll;
    logic [BANK_NUM-1:0][1:0]    w_win_slot;
    logic                        w_open;

    logic [BANK_NUM-1:0][PW-1:0] r_ptr;
    logic [BANK_NUM-1:0]         r_resp_valid;
    logic [BANK_NUM-1:0][CW-1:0] r_resp_coll;
    logic [BANK_NUM-1:0][1:0]    r_resp_slot;

    // (base + off) mod RQ, valid for base < RQ and off <= RQ
    function automatic logic [PW-1:0] f_wrap(
        input logic [PW-1:0] base,
        input int unsigned   off
    );
        logic [PW:0] v_sum;
        v_sum = {1'b0, base} + (PW+1)'(off);
        if (v_sum >= (PW+1)'(RQ))
            v_sum = v_sum - (PW+1)'(RQ);
        return v_sum[PW-1:0];
    endfunction

    assign w_open = rst_n & ~flush;

    // Warp swizzle: low bank bits of reg plus low bits of warp
    always_comb begin
        w_bank = '0;
        for (int r = 0; r < RQ; r++) begin
            w_bank[r] = req_reg[r*REG_NUM_WIDTH +: LB]
                      + req_warp[(r/RS_NUM)*WARP_NUM_WIDTH +: LB];
        end
    end

    always_comb begin
        w_elig = '0;
        for (int b = 0; b < BANK_NUM; b++) begin
            for (int r = 0; r < RQ; r++) begin
                w_elig[b][r] = req_valid[r]
                             && (w_bank[r] == LB'(b))
                             && !wr_busy[b]
                             && w_open;
            end
        end
    end

    always_comb begin
        logic [PW-1:0] v_idx;
        v_idx      = '0;
        req_grant  = '0;
        rf_rd_en   = '0;
        rf_rd_addr = '0;
        w_win      = '0;
        w_win_coll = '0;
        w_win_slot = '0;
        for (int b = 0; b < BANK_NUM; b++) begin
            // reverse scan: the smallest offset from ptr is written last
            for (int k = RQ - 1; k >= 0; k--) begin
                v_idx = f_wrap(r_ptr[b], unsigned'(k));
                if (w_elig[b][v_idx]) begin
                    rf_rd_en[b] = 1'b1;
                    w_win[b]    = v_idx;
                end
            end
            for (int r = 0; r < RQ; r++) begin
                if (rf_rd_en[b] && (w_win[b] == PW'(r))) begin
                    req_grant[r]          = 1'b1;
                    rf_rd_addr[b*AW +: AW] = {
                        req_warp[(r/RS_NUM)*WARP_NUM_WIDTH +: WARP_NUM_WIDTH],
                        req_reg[r*REG_NUM_WIDTH +: REG_NUM_WIDTH]
                    };
                    w_win_coll[b] = CW'(r / RS_NUM);
                    w_win_slot[b] = 2'(r % RS_NUM);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr        <= '0;
            r_resp_valid <= '0;
            r_resp_coll  <= '0;
            r_resp_slot  <= '0;
        end else begin
            r_resp_valid <= rf_rd_en & {BANK_NUM{~flush}};
            for (int b = 0; b < BANK_NUM; b++) begin
                if (rf_rd_en[b]) begin
                    r_ptr[b]       <= f_wrap(w_win[b], 1);
                    r_resp_coll[b] <= w_win_coll[b];
                    r_resp_slot[b] <= w_win_slot[b];
                end
            end
        end
    end

    // flush also kills responses already sitting in the output stage
    assign resp_valid     = r_resp_valid & {BANK_NUM{~flush}};
    assign resp_collector = r_resp_coll;
    assign resp_slot      = r_resp_slot;
    assign resp_data      = rf_rd_data;

endmodule

// File: tb/tb_gelato_bank_arbiter.sv
// Scoreboard bench for gelato_bank_arbiter: directed scenarios
// followed by random traffic against a behavioural model.
module tb_gelato_bank_arbiter;

    localparam int C  = 4;
    localparam int B  = 4;
    localparam int RS = 3;
    localparam int RW = 5;
    localparam int WW = 2;
    localparam int TN = 4;
    localparam int DW = 32;
    localparam int RQ = C * RS;
    localparam int AW = WW + RW;
    localparam int CW = 2;
    localparam int BD = TN * DW;

    logic              clk;
    logic              rst_n;
    logic [RQ-1:0]     req_valid;
    logic [C*WW-1:0]   req_warp;
    logic [RQ*RW-1:0]  req_reg;
    logic [B-1:0]      wr_busy;
    logic              flush;
    logic [RQ-1:0]     req_grant;
    logic [B-1:0]      rf_rd_en;
    logic [B*AW-1:0]   rf_rd_addr;
    logic [B*BD-1:0]   rf_rd_data;
    logic [B-1:0]      resp_valid;
    logic [B*CW-1:0]   resp_collector;
    logic [B*2-1:0]    resp_slot;
    logic [B*BD-1:0]   resp_data;

    gelato_bank_arbiter #(
        .COLLECTOR_NUM (C),
        .BANK_NUM      (B),
        .RS_NUM        (RS),
        .REG_NUM_WIDTH (RW),
        .WARP_NUM_WIDTH(WW),
        .THREAD_NUM    (TN),
        .DATA_WIDTH    (DW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_warp      (req_warp),
        .req_reg       (req_reg),
        .wr_busy       (wr_busy),
        .flush         (flush),
        .req_grant     (req_grant),
        .rf_rd_en      (rf_rd_en),
        .rf_rd_addr    (rf_rd_addr),
        .rf_rd_data    (rf_rd_data),
        .resp_valid    (resp_valid),
        .resp_collector(resp_collector),
        .resp_slot     (resp_slot),
        .resp_data     (resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int bank;
        int coll;
        int slot;
    } resp_t;

    typedef struct {
        int              cyc;
        logic [RQ-1:0]   grant;
        logic [B-1:0]    en;
        logic [B*AW-1:0] addr;
    } gexp_t;

    resp_t rq[$];
    gexp_t gq[$];

    int m_ptr[B];
    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    logic [RQ-1:0] tv_valid;
    int            tv_warp[C];
    int            tv_reg[RQ];
    logic [B-1:0]  tv_busy;
    logic          tv_flush;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [511:0] act,
                         input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic clr();
        tv_valid = '0;
        tv_busy  = '0;
        tv_flush = 1'b0;
        for (int c = 0; c < C; c++) tv_warp[c] = 0;
        for (int r = 0; r < RQ; r++) tv_reg[r] = 0;
    endtask

    task automatic setr(input int r, input int w, input int rg);
        tv_valid[r]   = 1'b1;
        tv_warp[r/RS] = w;
        tv_reg[r]     = rg;
    endtask

    // One clock of stimulus; the reference model predicts this cycle's
    // grants and next cycle's responses from the arbitration rules.
    task automatic cyc_go();
        gexp_t g;
        @(posedge clk);
        #1;
        req_valid = tv_valid;
        for (int c = 0; c < C; c++) req_warp[c*WW +: WW] = WW'(tv_warp[c]);
        for (int r = 0; r < RQ; r++) req_reg[r*RW +: RW] = RW'(tv_reg[r]);
        wr_busy = tv_busy;
        flush   = tv_flush;
        for (int w = 0; w < B*BD/32; w++) rf_rd_data[w*32 +: 32] = $urandom;
        g.cyc   = cyc;
        g.grant = '0;
        g.en    = '0;
        g.addr  = '0;
        if (tv_flush) begin
            for (int i = rq.size() - 1; i >= 0; i--)
                if (rq[i].cyc == cyc) rq.delete(i);
        end
        for (int b = 0; b < B; b++) begin
            int  win;
            bit  found;
            found = 0;
            win   = 0;
            if (!tv_busy[b] && !tv_flush) begin
                for (int k = 0; k < RQ; k++) begin
                    int r;
                    r = (m_ptr[b] + k) % RQ;
                    if (!found && tv_valid[r]
                        && ((tv_reg[r] + tv_warp[r/RS]) % B) == b) begin
                        found = 1;
                        win   = r;
                    end
                end
            end
            if (found) begin
                g.grant[win] = 1'b1;
                g.en[b]      = 1'b1;
                g.addr[b*AW +: AW] = AW'(tv_warp[win/RS] * (1 << RW) + tv_reg[win]);
                m_ptr[b] = (win + 1) % RQ;
                rq.push_back('{cyc + 1, b, win / RS, win % RS});
            end
        end
        gq.push_back(g);
    endtask

    always @(negedge clk) begin : mon
        gexp_t        g;
        resp_t        x;
        logic [B-1:0] ev;
        int           ec[B];
        int           es[B];
        if (gq.size() > 0 && gq[0].cyc == cyc) begin
            g = gq.pop_front();
            check("req_grant", 512'(req_grant), 512'(g.grant));
            check("rf_rd_en", 512'(rf_rd_en), 512'(g.en));
            check("rf_rd_addr", 512'(rf_rd_addr), 512'(g.addr));
        end
        ev = '0;
        for (int b = 0; b < B; b++) begin
            ec[b] = 0;
            es[b] = 0;
        end
        while (rq.size() > 0 && rq[0].cyc <= cyc) begin
            x = rq.pop_front();
            if (x.cyc == cyc) begin
                ev[x.bank] = 1'b1;
                ec[x.bank] = x.coll;
                es[x.bank] = x.slot;
            end
        end
        for (int b = 0; b < B; b++) begin
            check("resp_valid", 512'(resp_valid[b]), 512'(ev[b]));
            if (ev[b]) begin
                check("resp_collector", 512'(resp_collector[b*CW +: CW]),
                      512'(ec[b]));
                check("resp_slot", 512'(resp_slot[b*2 +: 2]), 512'(es[b]));
                check("resp_data", 512'(resp_data[b*BD +: BD]),
                      512'(rf_rd_data[b*BD +: BD]));
            end
        end
    end

    task automatic reset_outputs_zero(input string tag);
        check({tag, "_resp_valid"}, 512'(resp_valid), 512'(0));
        check({tag, "_resp_collector"}, 512'(resp_collector), 512'(0));
        check({tag, "_resp_slot"}, 512'(resp_slot), 512'(0));
        check({tag, "_req_grant"}, 512'(req_grant), 512'(0));
        check({tag, "_rf_rd_en"}, 512'(rf_rd_en), 512'(0));
        check({tag, "_rf_rd_addr"}, 512'(rf_rd_addr), 512'(0));
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = '0;
        req_warp   = '0;
        req_reg    = '0;
        wr_busy    = '0;
        flush      = 1'b0;
        rf_rd_data = '0;
        for (int b = 0; b < B; b++) m_ptr[b] = 0;
        clr();
        repeat (3) @(posedge clk);
        #1;
        reset_outputs_zero("por");
        rst_n = 1'b1;

        // single request: warp 0, reg 5 -> bank 1
        setr(0, 0, 5);
        cyc_go();
        clr();
        cyc_go();

        // three requesters on bank 2 held high: round-robin 0,4,8,0
        setr(0, 0, 2);
        setr(4, 0, 6);
        setr(8, 0, 10);
        repeat (4) cyc_go();
        clr();
        cyc_go();

        // warp 1, regs 0..3 -> banks 1,2,3,0 all in one cycle
        setr(0, 1, 0);
        setr(1, 1, 1);
        setr(2, 1, 2);
        setr(3, 1, 3);
        cyc_go();
        clr();
        cyc_go();

        // bank 3 blocked by writeback for two cycles, bank 0 unaffected
        setr(0, 0, 3);
        setr(3, 0, 4);
        tv_busy = 4'b1000;
        cyc_go();
        tv_valid[3] = 1'b0;
        cyc_go();
        tv_busy = '0;
        cyc_go();
        clr();
        cyc_go();

        // flush the cycle after a grant; the held request retries
        setr(5, 0, 1);
        cyc_go();
        tv_flush = 1'b1;
        cyc_go();
        tv_flush = 1'b0;
        cyc_go();
        clr();
        cyc_go();

        // reset while a response is in flight
        setr(0, 0, 2);
        setr(4, 0, 6);
        cyc_go();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        rq.delete();
        gq.delete();
        for (int b = 0; b < B; b++) m_ptr[b] = 0;
        #1;
        reset_outputs_zero("midrst");
        @(posedge clk);
        #1;
        req_valid = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc_go();
        tv_valid[0] = 1'b0;
        cyc_go();
        clr();
        cyc_go();

        // random traffic
        for (int n = 0; n < 400; n++) begin
            tv_valid = RQ'($urandom);
            for (int c = 0; c < C; c++) tv_warp[c] = $urandom_range(0, 3);
            for (int r = 0; r < RQ; r++) tv_reg[r] = $urandom_range(0, 31);
            for (int b = 0; b < B; b++) tv_busy[b] = ($urandom_range(0, 7) == 0);
            tv_flush = ($urandom_range(0, 15) == 0);
            cyc_go();
        end

        clr();
        repeat (3) cyc_go();
        @(negedge clk);
        check("drain_resp_queue", 512'(rq.size()), 512'(0));
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/gelato_bank_arbiter.md
Name: gelato_bank_arbiter

Overview:
- Arbitrates operand-collector register reads across the banked vector register file.
- Each collector holds up to 3 source operands (rs1/rs2/rs3). Each bank serves one read per cycle.
- Picks one requester per bank per cycle using round-robin, drives the bank read port, and one cycle later tags the returned `warp_reg_t` with the collector/slot that owns it.
- Sits between the collector array and the register-file banks, ahead of issue to the ALU.

Parameters:
- COLLECTOR_NUM, 4, number of operand collectors (C).
- BANK_NUM, 4, number of register-file banks (power of 2, B).
- RS_NUM, 3, operand slots per collector.
- REG_NUM_WIDTH, 5, width of `reg_num_t`.
- WARP_NUM_WIDTH, 2, width of `warp_num_t`.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  C*RS_NUM  operand-read request; bit r = c*RS_NUM+s
- req_warp  in  C*WARP_NUM_WIDTH  warp of each collector
- req_reg  in  C*RS_NUM*REG_NUM_WIDTH  register number per slot
- wr_busy  in  B  bank write port in use by writeback this cycle (write has priority)
- flush  in  1  drop all in-flight responses and block grants this cycle
- req_grant  out  C*RS_NUM  one-hot-per-bank grant, combinational, same cycle
- rf_rd_en  out  B  bank read enable
- rf_rd_addr  out  B*(WARP_NUM_WIDTH+REG_NUM_WIDTH)  {warp, reg} per bank
- rf_rd_data  in  B*THREAD_NUM*DATA_WIDTH  bank read data, registered 1 cycle after rf_rd_en
- resp_valid  out  B  response valid for bank b
- resp_collector  out  B*log2(C)  collector owning the response
- resp_slot  out  B*2  operand slot (0=rs1, 1=rs2, 2=rs3)
- resp_data  out  B*THREAD_NUM*DATA_WIDTH  pass-through of rf_rd_data

Behaviour:
- Bank mapping: bank(r) = (reg[log2B-1:0] + warp[log2B-1:0]) mod BANK_NUM, so consecutive warps are swizzled across banks.
- Per bank b, requester r is eligible iff:
  - req_valid[r]
  - bank(r)==b
  - !wr_busy[b]
  - !flush
- Arbitration: the winner is the first eligible r scanning from ptr[b] upward, wrapping at C*RS_NUM.
  - On grant: ptr[b] <= (winner+1) mod (C*RS_NUM). With no grant, ptr[b] holds.
  - ptr resets to 0.
- Grant outputs (combinational, same cycle as the request):
  - req_grant[winner]=1
  - rf_rd_en[b]=1
  - rf_rd_addr[b]={req_warp, req_reg} of the winner
- A requester maps to exactly one bank, so it receives at most one grant per cycle.
- Collector contract: on seeing req_grant, the collector drops that req_valid bit from the next cycle. A bit still high is treated as a new request.
- Response pipeline, 1 stage:
  - Registered: resp_valid[b] <= rf_rd_en[b] && !flush; resp_collector/resp_slot <= winner's decoded IDs.
  - resp_data[b] is combinational from rf_rd_data[b] (the regfile output is already registered).
  - Total latency is request to resp_valid = 1 cycle.
- flush:
  - Same cycle: zero grants and zero rf_rd_en.
  - Next cycle: resp_valid=0 for responses launched the previous cycle.
  - ptr is unchanged.
- wr_busy[b]: bank b grants nothing that cycle; ptr[b] holds; other banks are unaffected.
- Reset state (async assert, sync-safe deassert): resp_valid=0, resp_collector=0, resp_slot=0, ptr=0. Combinational outputs are 0 because no grants occur while rst_n=0.
- Reset mid-operation: in-flight responses are discarded, with no response after reset release.
- An idle bank drives rf_rd_addr=0 and rf_rd_en=0.

Test Plan:
- Single request: C0 rs1 = warp 0, reg 5 → bank 1. Expect req_grant[0]=1 and rf_rd_en=4'b0010 with addr {0,5} in the same cycle. Next cycle: resp_valid[1]=1, collector 0, slot 0, data = driven bank data.
- Conflict plus round-robin: C0.rs1, C1.rs2 and C2.rs3 all map to bank 2 and are held high. Expect grants on r=0, then r=4, then r=8, then r=0 again on successive cycles; ptr[2] goes 1 → 5 → 9 → 1.
- Parallel banks: 4 requests on distinct banks (warp 1, regs 0..3 → banks 1, 2, 3, 0). Expect all 4 granted in one cycle and 4 resp_valid the next cycle with the correct IDs.
- Write priority: bank 3 request with wr_busy[3]=1 for 2 cycles. Expect no grant and ptr held; grant on the 3rd cycle. A concurrent request on bank 0 is granted in cycle 1.
- Flush: grant in cycle t, flush=1 in cycle t+1. Expect resp_valid=0 in t+1 and no grants in t+1. A held request is granted in t+2.
- Reset mid-flight: grant in cycle t, rst_n low in t+1. Expect resp_valid=0 immediately and ptr=0. After release, the first grant goes to the lowest eligible index.
